// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: default widths, FSM state encoding, counter sizing.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_DIVIDEND_W);

endpackage

// File: rtl/divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface divider_if #(
  parameter int DIVIDEND_W = div_pkg::DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = div_pkg::DEF_DIVISOR_W
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem, quo} left, conditionally subtract divisor.
module div_step
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W-1:0]  rem_in,
  input  logic [DIVIDEND_W-1:0] quo_in,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVISOR_W-1:0]  rem_out,
  output logic [DIVIDEND_W-1:0] quo_out
);
  logic [DIVISOR_W:0] shifted;
  logic               ge;

  assign shifted = {rem_in, quo_in[DIVIDEND_W-1]};
  assign ge      = shifted >= {1'b0, divisor};
  // Either branch fits DIVISOR_W bits; with divisor 0 the truncation keeps the low dividend bits.
  assign rem_out = DIVISOR_W'(ge ? shifted - {1'b0, divisor} : shifted);
  assign quo_out = {quo_in[DIVIDEND_W-2:0], ge};
endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per RUN cycle.
// Define DIVIDER_ZERO_DETECT_EN to short-circuit divide-by-zero and raise div_by_zero.
module divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input logic      clk,
  input logic      rst,
  divider_if.slave bus
);
  localparam int CW = cnt_w(DIVIDEND_W);

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, quo_step, quo_q;
  logic [DIVISOR_W-1:0]  dvs_q, rem_q, rem_step, rmd_q;
  logic [CW-1:0]         cnt_q;
  logic                  accept, finish, last_step, zero_hit;

`ifdef DIVIDER_ZERO_DETECT_EN
  logic zero_q, dbz_q;
  assign zero_hit = zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      if (accept) zero_q <= (bus.divisor == '0);
      if (finish) dbz_q  <= zero_q;
    end
  end

  assign bus.div_by_zero = dbz_q;
`else
  assign zero_hit        = 1'b0;
  assign bus.div_by_zero = 1'b0;
`endif

  div_step #(
    .DIVIDEND_W(DIVIDEND_W),
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in (rem_q),
    .quo_in (dvd_q),
    .divisor(dvs_q),
    .rem_out(rem_step),
    .quo_out(quo_step)
  );

  assign last_step = (cnt_q == CW'(DIVIDEND_W - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: if (zero_hit || last_step) begin
        finish  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        accept  = bus.start;
        state_d = bus.start ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // dvd_q doubles as the quotient shift register once RUN starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
    end else begin
      if (accept) begin
        dvd_q <= bus.dividend;
        dvs_q <= bus.divisor;
        rem_q <= '0;
        cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        dvd_q <= quo_step;
        rem_q <= rem_step;
        cnt_q <= cnt_q + CW'(1);
      end
      if (finish) begin
        quo_q <= zero_hit ? '1 : quo_step;
        rmd_q <= zero_hit ? dvd_q[DIVISOR_W-1:0] : rem_step;
      end
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;
endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider: latency, results, start/reset interactions.
module tb_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  divider_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

  divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch an operation; lat = posedges after the accept edge until done is seen, -1 on timeout.
  task automatic go(input logic [15:0] a, input logic [7:0] b, input int inj_s, input int inj_r,
                    input bit hold, output int lat, output logic busy1);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); @(negedge clk);
    busy1 = bus.busy;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n - 1 == inj_s) begin
        bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 8'd3;
      end else if (!hold) bus.start = 1'b0;
      rst = (n - 1 == inj_r);
      @(posedge clk); @(negedge clk);
      if (bus.done) begin lat = n; break; end
    end
    rst = 1'b0;
  endtask

  initial begin
    int   lat, zlat, n2;
    logic b1, zdbz;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quo", bus.quotient, 0);
    chk("rst_rem", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);

    go(16'd1000, 8'd7, -1, -1, 1'b0, lat, b1);
    chk("1000/7_busy", b1, 1);
    chk("1000/7_lat", lat, 16);
    chk("1000/7_q", bus.quotient, 142);
    chk("1000/7_r", bus.remainder, 6);
    chk("1000/7_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    chk("done_pulse_1cyc", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
    chk("quo_hold_idle", bus.quotient, 142);

    go(16'hFFFF, 8'hFF, -1, -1, 1'b0, lat, b1);
    chk("ffff/ff_lat", lat, 16);
    chk("ffff/ff_q", bus.quotient, 257);
    chk("ffff/ff_r", bus.remainder, 0);

    go(16'd5, 8'd10, -1, -1, 1'b0, lat, b1);
    chk("5/10_q", bus.quotient, 0);
    chk("5/10_r", bus.remainder, 5);

`ifdef DIVIDER_ZERO_DETECT_EN
    zlat = 1; zdbz = 1'b1;
`else
    zlat = 16; zdbz = 1'b0;
`endif
    go(16'h1234, 8'd0, -1, -1, 1'b0, lat, b1);
    chk("div0_lat", lat, zlat);
    chk("div0_q", bus.quotient, 16'hFFFF);
    chk("div0_r", bus.remainder, 8'h34);
    chk("div0_dbz", bus.div_by_zero, zdbz);

    go(16'd100, 8'd9, 4, -1, 1'b0, lat, b1);
    chk("ignore_start_lat", lat, 16);
    chk("ignore_start_q", bus.quotient, 11);
    chk("ignore_start_r", bus.remainder, 1);
    @(negedge clk);
    chk("ignore_start_idle", bus.busy, 0);

    go(16'd200, 8'd13, -1, 7, 1'b0, lat, b1);
    chk("abort_no_done", lat, -1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_q", bus.quotient, 0);
    chk("abort_r", bus.remainder, 0);
    chk("abort_dbz", bus.div_by_zero, 0);
    go(16'd200, 8'd13, -1, -1, 1'b0, lat, b1);
    chk("after_abort_lat", lat, 16);
    chk("after_abort_q", bus.quotient, 15);
    chk("after_abort_r", bus.remainder, 5);

    // reset and start in the same cycle: reset must win
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.dividend = 16'd7; bus.divisor = 8'd1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_prio_busy", bus.busy, 0);
    chk("rst_prio_q", bus.quotient, 0);
    @(negedge clk);
    chk("rst_prio_idle", bus.busy, 0);

    go(16'd60000, 8'd250, -1, -1, 1'b1, lat, b1);
    chk("b2b1_lat", lat, 16);
    chk("b2b1_q", bus.quotient, 240);
    chk("b2b1_r", bus.remainder, 0);
    bus.dividend = 16'd255; bus.divisor = 8'd16;
    n2 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0;
        chk("b2b_busy", bus.busy, 1);
        chk("b2b_q_hold", bus.quotient, 240);
      end
      if (bus.done) begin n2 = n; break; end
    end
    chk("b2b_spacing", n2, 17);
    chk("b2b2_q", bus.quotient, 15);
    chk("b2b2_r", bus.remainder, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter DIVIDEND_W, default 16: dividend and quotient width.
REQ-002 Parameter DIVISOR_W, default 8: divisor and remainder width.
REQ-003 clk  input  1  rising-edge clock, the only clock in the block.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 dividend  input  DIVIDEND_W  unsigned numerator, captured when start is accepted.
REQ-007 divisor  input  DIVISOR_W  unsigned denominator, captured when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse; quotient and remainder are valid in this cycle.
REQ-010 quotient  output  DIVIDEND_W  unsigned result.
REQ-011 remainder  output  DIVISOR_W  unsigned result.
REQ-012 div_by_zero  output  1  error flag; qualified by done.

Function
REQ-013 The block SHALL use an FSM with the states IDLE, RUN and DONE.
REQ-014 Transitions SHALL be:
- IDLE to RUN on start.
- RUN to DONE after DIVIDEND_W iterations.
- DONE to RUN on start, otherwise DONE to IDLE.
REQ-015 On acceptance at edge k, the block SHALL capture the operands, clear the partial remainder and clear the iteration counter.
REQ-016 Each RUN cycle SHALL perform one restoring step:
- shift {partial_rem, dividend_reg} left by one bit;
- if partial_rem (DIVISOR_W+1 bits) >= divisor, subtract divisor and set the new quotient LSB to 1, otherwise set it to 0.
REQ-017 Latency SHALL be fixed:
- busy high during the cycles following edges k..k+DIVIDEND_W-1;
- done high for exactly one cycle, following edge k+DIVIDEND_W (16 cycles at the defaults).
REQ-018 quotient and remainder SHALL update only when entering DONE and SHALL hold their values until the next DONE.
REQ-019 The block SHALL ignore start while in RUN, with no effect on the operation in progress.
REQ-020 Start asserted in the DONE cycle SHALL be accepted, allowing back-to-back operations.
REQ-021 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor whenever divisor != 0.
REQ-022 When divisor == 0, the block SHALL return quotient all-ones and remainder = dividend[DIVISOR_W-1:0].

Reset
REQ-023 rst high at a rising edge SHALL force IDLE and clear busy, done, quotient, remainder, div_by_zero and all internal registers to 0.
REQ-024 Reset SHALL take priority over start in the same cycle.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-026 The macro DIVIDER_ZERO_DETECT_EN SHALL control divide-by-zero handling.
REQ-027 With DIVIDER_ZERO_DETECT_EN defined:
- divisor == 0 at acceptance SHALL skip RUN and enter DONE at edge k+1;
- div_by_zero SHALL be 1 with done;
- results SHALL follow REQ-022.
REQ-028 Without DIVIDER_ZERO_DETECT_EN:
- divisor == 0 SHALL run the full DIVIDEND_W iterations, producing the REQ-022 values naturally;
- div_by_zero SHALL be tied to 0.

Structure
REQ-029 A shared package div_pkg SHALL hold:
- the DIVIDEND_W and DIVISOR_W defaults;
- the state encoding constants ST_IDLE, ST_RUN, ST_DONE;
- the counter width constant CNT_W = clog2(DIVIDEND_W+1).
REQ-030 One combinational sub-module, div_step, SHALL implement a single shift/compare/subtract iteration, instantiated once.

Verification
REQ-031 dividend=1000, divisor=7 -> done 16 cycles after the start edge; quotient=142, remainder=6.
REQ-032 dividend=0xFFFF, divisor=0xFF -> quotient=257, remainder=0. Also dividend=5, divisor=10 -> quotient=0, remainder=5.
REQ-033 dividend=0x1234, divisor=0:
- with the macro: done 1 cycle after start, div_by_zero=1, quotient=0xFFFF, remainder=0x34;
- without the macro: done after 16 cycles, same values, div_by_zero=0.
REQ-034 Start 100/9, then pulse start with 50/3 at cycle 5 of RUN -> the second request is ignored; result is quotient=11, remainder=1.
REQ-035 Start 200/13, assert rst at cycle 8 of RUN -> no done pulse, all outputs 0, busy 0. A following start with 200/13 -> quotient=15, remainder=5.
REQ-036 Back-to-back operations with start held through DONE: 60000/250 then 255/16 -> quotient=240, remainder=0, then quotient=15, remainder=15, with done pulses 17 cycles apart.
